// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encodings and redirect priority codes for the PC sequencer
package pc_sequencer_pkg;

  // FSM state encodings; the numeric values are visible on state_o
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HAZ  = 2'd1,
    ST_HALT = 2'd2,
    ST_PEND = 2'd3
  } state_t;

  // Redirect priority codes; a larger code is a more urgent redirect
  typedef enum logic [1:0] {
    PRI_NONE = 2'd0,
    PRI_JMP  = 2'd1,
    PRI_BR   = 2'd2,
    PRI_EXC  = 2'd3
  } redir_pri_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_CNT_W  = 16;

  // Saturating increment: an all-ones count stays all-ones
  function automatic logic sat_can_inc(input logic [63:0] cnt, input int width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (cnt != max_val);
  endfunction

endpackage

// File: rtl/pc_redirect_pri.sv
// rtl/pc_redirect_pri.sv - combinational priority select among exception, branch and jump redirects
module pc_redirect_pri
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'('h0000_0100)
) (
  input  logic              exc_req,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_target,
  output logic              valid,
  output logic [ADDR_W-1:0] target,
  output redir_pri_t        pri
);

  // Exception beats branch beats jump; nothing asserted means no redirect
  always_comb begin
    valid  = 1'b0;
    target = '0;
    pri    = PRI_NONE;
    if (exc_req) begin
      valid  = 1'b1;
      target = EXC_VEC;
      pri    = PRI_EXC;
    end else if (br_taken) begin
      valid  = 1'b1;
      target = br_target;
      pri    = PRI_BR;
    end else if (jmp_valid) begin
      valid  = 1'b1;
      target = jmp_target;
      pri    = PRI_JMP;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC selection, hazard stall, debug halt and pending-redirect FSM
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'('h0000_0100),
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic [ADDR_W-1:0] pc4,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              exc_req,
  input  logic              hazard,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] mux_pc,
  output logic              stall,
  output logic              flush,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pend_pc, pend_pc_nxt;
  redir_pri_t        pend_pri, pend_pri_nxt;

  logic              rd_valid;
  logic [ADDR_W-1:0] rd_target;
  redir_pri_t        rd_pri;

  logic halt_go;
  logic resume_go;
  logic pend_take;

  pc_redirect_pri #(
    .ADDR_W  (ADDR_W),
    .EXC_VEC (EXC_VEC)
  ) u_pri (
    .exc_req    (exc_req),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp_valid  (jmp_valid),
    .jmp_target (jmp_target),
    .valid      (rd_valid),
    .target     (rd_target),
    .pri        (rd_pri)
  );

  // halt and resume together cancel out; a new redirect replaces the pending one only if at least as urgent
  always_comb begin
    halt_go   = halt_req & ~resume;
    resume_go = resume & ~halt_req;
    pend_take = rd_valid && (rd_pri >= pend_pri);
  end

  // Next-state, pending-redirect latch and PC-register controls
  always_comb begin
    state_nxt    = state;
    pend_pc_nxt  = pend_pc;
    pend_pri_nxt = pend_pri;
    mux_pc       = pc4;
    stall        = 1'b0;
    flush        = 1'b0;
    if (rst) begin
      state_nxt    = ST_RUN;
      pend_pc_nxt  = '0;
      pend_pri_nxt = PRI_NONE;
      mux_pc       = '0;
      stall        = 1'b1;
      flush        = 1'b1;
    end else begin
      case (state)
        ST_RUN, ST_HAZ: begin
          if (rd_valid && halt_go) begin
            // Halting wins the PC register; the redirect waits in pend_pc until resume
            stall        = 1'b1;
            flush        = 1'b1;
            mux_pc       = pc_cur;
            pend_pc_nxt  = rd_target;
            pend_pri_nxt = rd_pri;
            state_nxt    = ST_PEND;
          end else if (rd_valid) begin
            flush     = 1'b1;
            mux_pc    = rd_target;
            state_nxt = ST_RUN;
          end else if (halt_go) begin
            if (hazard) begin
              stall  = 1'b1;
              mux_pc = pc_cur;
            end
            state_nxt = ST_HALT;
          end else if (hazard) begin
            stall     = 1'b1;
            mux_pc    = pc_cur;
            state_nxt = ST_HAZ;
          end else begin
            state_nxt = ST_RUN;
          end
        end
        ST_HALT: begin
          stall  = 1'b1;
          mux_pc = pc_cur;
          if (rd_valid) begin
            flush        = 1'b1;
            pend_pc_nxt  = rd_target;
            pend_pri_nxt = rd_pri;
            state_nxt    = ST_PEND;
          end else if (resume_go) begin
            stall     = 1'b0;
            mux_pc    = pc4;
            state_nxt = ST_RUN;
          end
        end
        ST_PEND: begin
          if (resume_go) begin
            flush        = 1'b1;
            mux_pc       = pend_take ? rd_target : pend_pc;
            pend_pc_nxt  = '0;
            pend_pri_nxt = PRI_NONE;
            state_nxt    = ST_RUN;
          end else begin
            stall  = 1'b1;
            mux_pc = pc_cur;
            if (rd_valid) begin
              flush = 1'b1;
            end
            if (pend_take) begin
              pend_pc_nxt  = rd_target;
              pend_pri_nxt = rd_pri;
            end
          end
        end
        default: begin
          state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // State and pending-redirect registers; reset values come from the rst branch above
  always_ff @(posedge clk) begin
    state    <= state_nxt;
    pend_pc  <= pend_pc_nxt;
    pend_pri <= pend_pri_nxt;
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && sat_can_inc(64'(stall_cnt), CNT_W)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign state_o = state;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC width in words.
REQ-002 SHALL have parameter EXC_VEC, default 'h0000_0100, exception entry PC.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port pc_cur  in  ADDR_W  current PC from pc register.
REQ-007 SHALL have port pc4  in  ADDR_W  pc_cur+1 from pc register.
REQ-008 SHALL have ports br_taken in 1 and br_target in ADDR_W  resolved branch redirect.
REQ-009 SHALL have ports jmp_valid in 1 and jmp_target in ADDR_W  jump redirect.
REQ-010 SHALL have port exc_req  in  1  exception request, one-cycle pulse.
REQ-011 SHALL have port hazard  in  1  load-use hazard, level.
REQ-012 SHALL have ports halt_req in 1 and resume in 1  debug halt/resume pulses.
REQ-013 SHALL have port mux_pc  out  ADDR_W  next PC to pc register.
REQ-014 SHALL have port stall  out  1  pc register hold.
REQ-015 SHALL have port flush  out  1  kill IF/ID instructions this cycle.
REQ-016 SHALL have port state_o  out  2  FSM state, for debug.
REQ-017 SHALL have port stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-018 SHALL implement states RUN=0, HAZ=1, HALT=2, PEND=3.
REQ-019 SHALL apply redirect priority exc_req > br_taken > jmp_valid > sequential; mux_pc = EXC_VEC / br_target / jmp_target / pc4, all combinational in the same cycle.
REQ-020 RUN: any redirect SHALL drive flush=1 and stall=0; hazard with no redirect SHALL drive stall=1 and mux_pc=pc_cur, then go to HAZ.
REQ-021 HAZ: stall=1 while hazard=1; hazard=0 SHALL return to RUN with stall=0 that cycle.
REQ-022 HAZ: a redirect SHALL override the stall (stall=0, flush=1, mux_pc=target) and go to RUN.
REQ-023 halt_req in RUN or HAZ SHALL go to HALT next cycle; stall=1 and mux_pc=pc_cur every HALT cycle.
REQ-024 A redirect in the same cycle as halt_req SHALL be latched (target in pend_pc, flush=1) and the FSM SHALL go to PEND instead of HALT.
REQ-025 A redirect arriving in HALT SHALL be latched into pend_pc with flush=1 and the FSM SHALL move to PEND; a later redirect in PEND SHALL overwrite pend_pc only if its priority is greater than or equal to the stored one.
REQ-026 resume in HALT SHALL go to RUN with stall=0 and mux_pc=pc4.
REQ-027 resume in PEND SHALL drive mux_pc=pend_pc, stall=0, flush=1, then go to RUN.
REQ-028 exc_req SHALL be honoured in every state, including HALT and PEND via the latch rule.
REQ-029 stall_cnt SHALL increment on each cycle with stall=1, saturate at all-ones and not wrap.
REQ-030 All PC arithmetic SHALL be ADDR_W bits modulo 2^ADDR_W; pc4 at all-ones equals 0 and is passed through unchanged.
REQ-031 resume with halt_req simultaneously SHALL be ignored: the FSM stays in its current state.

Reset
REQ-032 While rst=1: state=RUN, stall=1, flush=1, mux_pc=0, pend_pc=0, stall_cnt=0.
REQ-033 Reset mid-HALT or mid-PEND SHALL discard any pending redirect.
REQ-034 The first cycle after rst deasserts SHALL behave as RUN.

Structure
REQ-035 State encodings and redirect-priority codes SHALL live in the shared package with the existing global defines.
REQ-036 The design SHALL use one sub-module, pc_redirect_pri: a combinational priority select returning a valid flag, target and priority code.

Verification
REQ-037 Sequential run: pc_cur=5, pc4=6, no events -> mux_pc=6, stall=0, flush=0.
REQ-038 Hazard for 3 cycles -> stall=1 for exactly 3 cycles, mux_pc=pc_cur, stall_cnt=3, then mux_pc=pc4.
REQ-039 br_taken (target 0x40) with jmp_valid (0x80) and hazard in HAZ -> mux_pc=0x40, stall=0, flush=1, state RUN.
REQ-040 halt_req, then br_taken target 0x20 in HALT, then resume -> state PEND, then mux_pc=0x20 with flush=1, then RUN.
REQ-041 exc_req with br_taken -> mux_pc=EXC_VEC; rst in PEND -> pend_pc cleared, first post-reset mux_pc=pc4.
REQ-042 Saturation: CNT_W=4 with 20 stall cycles -> stall_cnt holds 15.
